// File: rtl/rv_core_pkg.sv
// Shared core definitions: register address width, address type and the
// register-count derivation used by the issue-stage scoreboard.
package rv_core_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Number of architectural registers addressed by a w-bit index
    function automatic int unsigned nreg(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Parametrised binary-to-one-hot decoder; all-zero output when en is low.
module onehot_decoder #(
    parameter int unsigned IN_W = 5
) (
    input  logic                 en,
    input  logic [IN_W-1:0]      in,
    output logic [2**IN_W-1:0]   out
);

    // Single hot bit at position in, only while enabled
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard for the issue stage: tracks in-flight writes,
// answers RAW queries with writeback bypass and stalls WAW issues.
// Optional feature macro: X0_HARDWIRED_EN (register 0 is never tracked).
module reg_scoreboard
    import rv_core_pkg::*;
#(
    parameter  int unsigned ADDR_W = REG_ADDR_W,
    parameter  int unsigned NQ     = 2,
    localparam int unsigned NREG   = nreg(ADDR_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic                 issue_ready,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic                 flush,
    input  logic [NQ*ADDR_W-1:0] q_rs,
    output logic [NQ-1:0]        q_busy,
    output logic [NREG-1:0]      busy_vec,
    output logic                 wb_err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            wb_err_q, wb_err_d;
    logic [NREG-1:0] set_oh, clr_oh;
    logic            issue_fire;
    logic            set_en;
    logic            wb_stray;

    assign issue_fire = issue_valid && issue_ready;

`ifdef X0_HARDWIRED_EN
    assign set_en   = issue_fire && (issue_rd != '0);
    assign wb_stray = wb_valid && !flush && !busy_q[wb_rd] && (wb_rd != '0);
`else
    assign set_en   = issue_fire;
    assign wb_stray = wb_valid && !flush && !busy_q[wb_rd];
`endif

    onehot_decoder #(.IN_W(ADDR_W)) u_set_dec (
        .en  (set_en),
        .in  (issue_rd),
        .out (set_oh)
    );

    onehot_decoder #(.IN_W(ADDR_W)) u_clr_dec (
        .en  (wb_valid),
        .in  (wb_rd),
        .out (clr_oh)
    );

    // Issue handshake: stall on a pending write unless it retires this cycle
    always_comb begin
        issue_ready = 1'b0;
        if (!flush) begin
            issue_ready = !busy_q[issue_rd] || (wb_valid && (wb_rd == issue_rd));
        end
    end

    // RAW query per source port, bypassing a register retiring this cycle
    always_comb begin
        q_busy = '0;
        for (int unsigned k = 0; k < NQ; k++) begin
            q_busy[k] = busy_q[q_rs[k*ADDR_W +: ADDR_W]] &&
                        !(wb_valid && (wb_rd == q_rs[k*ADDR_W +: ADDR_W]));
        end
    end

    // Next state: flush wins, else clear then set so a same-cycle reissue stays busy
    always_comb begin
        busy_d   = (busy_q & ~clr_oh) | set_oh;
        wb_err_d = wb_err_q | wb_stray;
        if (flush) begin
            busy_d = '0;
        end
`ifdef X0_HARDWIRED_EN
        busy_d[0] = 1'b0;
`endif
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec = busy_q;
    assign wb_err   = wb_err_q;

endmodule
